// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants, writeback request record and a small one-hot helper.
package regfile_pkg;

  localparam int OPRAND_WIDTH  = 32;
  localparam int REGNAME_WIDTH = 5;
  localparam int NUM_WB_REQ    = 4;
  localparam int MAX_REQ       = 8;

  typedef struct packed {
    logic                     valid;
    logic [REGNAME_WIDTH-1:0] addr;
    logic [OPRAND_WIDTH-1:0]  data;
  } wb_req_t;

  function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) onehot_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick2.sv
// Rotating two-hit picker: first valid request from ptr_i wins slot A, the next one
// with a different address wins slot B. Same-address requests are masked for this cycle.
module rr_pick2
  import regfile_pkg::*;
#(
  parameter int N  = NUM_WB_REQ,
  parameter int AW = REGNAME_WIDTH,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    valid_i,
  input  logic [N*AW-1:0] addr_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [N-1:0]    slot_a_o,
  output logic [N-1:0]    slot_b_o,
  output logic            hit_a_o,
  output logic            hit_b_o
);

  int          idx;
  logic [AW-1:0] addr_a;

  always_comb begin
    slot_a_o = '0;
    slot_b_o = '0;
    hit_a_o  = 1'b0;
    hit_b_o  = 1'b0;
    addr_a   = '0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (valid_i[idx]) begin
        if (!hit_a_o) begin
          hit_a_o       = 1'b1;
          slot_a_o[idx] = 1'b1;
          addr_a        = addr_i[idx*AW +: AW];
        end else if (!hit_b_o && (addr_i[idx*AW +: AW] != addr_a)) begin
          hit_b_o       = 1'b1;
          slot_b_o[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter granting up to two conflict-free register-file writes per cycle,
// registered onto the two RAM write ports with one cycle of latency.
module regfile_write_arbiter
  import regfile_pkg::wb_req_t;
  import regfile_pkg::onehot_idx;
  import regfile_pkg::MAX_REQ;
#(
  parameter int NUM_REQ       = regfile_pkg::NUM_WB_REQ,
  parameter int OPRAND_WIDTH  = regfile_pkg::OPRAND_WIDTH,
  parameter int REGNAME_WIDTH = regfile_pkg::REGNAME_WIDTH,
  parameter bit DROP_ZERO     = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*REGNAME_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ*OPRAND_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic                              write1_en_o,
  output logic [REGNAME_WIDTH-1:0]          write1_addr_o,
  output logic [OPRAND_WIDTH-1:0]           write1_data_o,
  output logic                              write2_en_o,
  output logic [REGNAME_WIDTH-1:0]          write2_addr_o,
  output logic [OPRAND_WIDTH-1:0]           write2_data_o,
  output logic [15:0]                       stall_cnt_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wb_req_t              reqs [NUM_REQ];
  wb_req_t              a_req, b_req;
  logic [NUM_REQ-1:0]   valid_v, slot_a, slot_b;
  logic                 hit_a, hit_b;
  logic [MAX_REQ-1:0]   last_oh;
  int                   last_idx;

  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic                     w1_en_q, w1_en_d, w2_en_q, w2_en_d;
  logic [REGNAME_WIDTH-1:0] w1_addr_q, w1_addr_d, w2_addr_q, w2_addr_d;
  logic [OPRAND_WIDTH-1:0]  w1_data_q, w1_data_d, w2_data_q, w2_data_d;
  logic [15:0]              stall_q, stall_d;
  logic                     stall_any;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      reqs[k].valid = req_valid_i[k];
      reqs[k].addr  = req_addr_i[k*REGNAME_WIDTH +: REGNAME_WIDTH];
      reqs[k].data  = req_data_i[k*OPRAND_WIDTH +: OPRAND_WIDTH];
      valid_v[k]    = reqs[k].valid;
    end
  end

  rr_pick2 #(
    .N  (NUM_REQ),
    .AW (REGNAME_WIDTH),
    .PW (PW)
  ) u_pick (
    .valid_i  (valid_v),
    .addr_i   (req_addr_i),
    .ptr_i    (rr_ptr_q),
    .slot_a_o (slot_a),
    .slot_b_o (slot_b),
    .hit_a_o  (hit_a),
    .hit_b_o  (hit_b)
  );

  always_comb begin
    a_req = '0;
    b_req = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (slot_a[k]) a_req = reqs[k];
      if (slot_b[k]) b_req = reqs[k];
    end
  end

  assign req_ready_o = rst ? '0 : (slot_a | slot_b);

  // Slot B always lies later in scan order than slot A, so it is the last grant when present.
  always_comb begin
    last_oh                = '0;
    last_oh[NUM_REQ-1:0]   = hit_b ? slot_b : slot_a;
    last_idx               = int'(onehot_idx(last_oh));
    rr_ptr_d               = rr_ptr_q;
    if (hit_a) rr_ptr_d = (last_idx + 1 >= NUM_REQ) ? '0 : PW'(last_idx + 1);
  end

  always_comb begin
    w1_en_d   = hit_a && !(DROP_ZERO && (a_req.addr == '0));
    w2_en_d   = hit_b && !(DROP_ZERO && (b_req.addr == '0));
    w1_addr_d = w1_en_d ? a_req.addr : w1_addr_q;
    w1_data_d = w1_en_d ? a_req.data : w1_data_q;
    w2_addr_d = w2_en_d ? b_req.addr : w2_addr_q;
    w2_data_d = w2_en_d ? b_req.data : w2_data_q;
  end

  assign stall_any = |(req_valid_i & ~req_ready_o);
  assign stall_d   = (stall_any && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      w1_en_q   <= 1'b0;
      w1_addr_q <= '0;
      w1_data_q <= '0;
      w2_en_q   <= 1'b0;
      w2_addr_q <= '0;
      w2_data_q <= '0;
      stall_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      w1_en_q   <= w1_en_d;
      w1_addr_q <= w1_addr_d;
      w1_data_q <= w1_data_d;
      w2_en_q   <= w2_en_d;
      w2_addr_q <= w2_addr_d;
      w2_data_q <= w2_data_d;
      stall_q   <= stall_d;
    end
  end

  assign write1_en_o   = w1_en_q;
  assign write1_addr_o = w1_addr_q;
  assign write1_data_o = w1_data_q;
  assign write2_en_o   = w2_en_q;
  assign write2_addr_o = w2_addr_q;
  assign write2_data_o = w2_data_q;
  assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a scan-order queue model checked every cycle.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v;
  logic [4:0]  ad [4];
  logic [31:0] dt [4];
  logic [19:0] addr_bus;
  logic [127:0] data_bus;
  logic [3:0]  ready;
  logic        w1en, w2en;
  logic [4:0]  w1a, w2a;
  logic [31:0] w1d, w2d;
  logic [15:0] stall;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_ptr;
  logic        m_w1en, m_w2en;
  logic [4:0]  m_w1a, m_w2a;
  logic [31:0] m_w1d, m_w2d;
  logic [15:0] m_stall;
  int          q [$];
  int          ea, eb, last;
  logic [3:0]  exp_rdy;
  logic [31:0] shadow [32];

  always #5 clk = ~clk;

  always_comb begin
    addr_bus = '0;
    data_bus = '0;
    for (int k = 0; k < 4; k++) begin
      addr_bus[k*5 +: 5]   = ad[k];
      data_bus[k*32 +: 32] = dt[k];
    end
  end

  regfile_write_arbiter #(
    .NUM_REQ(4), .OPRAND_WIDTH(32), .REGNAME_WIDTH(5), .DROP_ZERO(1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (v),
    .req_addr_i    (addr_bus),
    .req_data_i    (data_bus),
    .req_ready_o   (ready),
    .write1_en_o   (w1en),
    .write1_addr_o (w1a),
    .write1_data_o (w1d),
    .write2_en_o   (w2en),
    .write2_addr_o (w2a),
    .write2_data_o (w2d),
    .stall_cnt_o   (stall)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 50) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_w1en", 64'(w1en), 64'd0);
      chk("rst_w2en", 64'(w2en), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      m_ptr = 0; m_w1en = 0; m_w2en = 0; m_w1a = 0; m_w2a = 0;
      m_w1d = 0; m_w2d = 0; m_stall = 0;
    end else begin
      chk("w1en", 64'(w1en), 64'(m_w1en));
      chk("w1addr", 64'(w1a), 64'(m_w1a));
      chk("w1data", 64'(w1d), 64'(m_w1d));
      chk("w2en", 64'(w2en), 64'(m_w2en));
      chk("w2addr", 64'(w2a), 64'(m_w2a));
      chk("w2data", 64'(w2d), 64'(m_w2d));
      chk("stall", 64'(stall), 64'(m_stall));
      q.delete();
      for (int i = 0; i < 4; i++) if (v[(m_ptr + i) % 4]) q.push_back((m_ptr + i) % 4);
      ea = -1; eb = -1;
      if (q.size() > 0) ea = q[0];
      for (int j = 1; j < q.size(); j++) if (eb < 0 && ad[q[j]] != ad[ea]) eb = q[j];
      exp_rdy = '0;
      if (ea >= 0) exp_rdy[ea] = 1'b1;
      if (eb >= 0) exp_rdy[eb] = 1'b1;
      chk("ready", 64'(ready), 64'(exp_rdy));
      if (w1en) shadow[w1a] = w1d;
      if (w2en) shadow[w2a] = w2d;
      m_w1en = (ea >= 0) && (ad[ea] != 0);
      m_w2en = (eb >= 0) && (ad[eb] != 0);
      if (m_w1en) begin m_w1a = ad[ea]; m_w1d = dt[ea]; end
      if (m_w2en) begin m_w2a = ad[eb]; m_w2d = dt[eb]; end
      if ((v & ~exp_rdy) != 0 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (ea >= 0) begin
        last  = (eb >= 0) ? eb : ea;
        m_ptr = (last + 1) % 4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    v = '0;
    for (int k = 0; k < 4; k++) begin ad[k] = '0; dt[k] = '0; end
  endtask

  task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
    v[k] = 1'b1; ad[k] = a; dt[k] = d;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    rst = 1'b1;
    clear_reqs();
    #1;
    chk("init_ready", 64'(ready), 64'd0);
    chk("init_w1en", 64'(w1en), 64'd0);
    chk("init_stall", 64'(stall), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // two non-conflicting requests
    set_req(0, 5'd3, 32'h11);
    set_req(2, 5'd7, 32'h22);
    #1;
    chk("two_ready", 64'(ready), 64'b0101);
    tick();
    chk("two_w1", {31'd0, w1en, 27'd0, w1a}, {31'd0, 1'b1, 27'd0, 5'd3});
    chk("two_w1d", 64'(w1d), 64'h11);
    chk("two_w2", {31'd0, w2en, 27'd0, w2a}, {31'd0, 1'b1, 27'd0, 5'd7});
    chk("two_w2d", 64'(w2d), 64'h22);
    clear_reqs();
    do_reset();

    // same-address conflict serialized over two cycles
    set_req(1, 5'd5, 32'hA1);
    set_req(3, 5'd5, 32'hB3);
    #1;
    chk("conf_ready_n", 64'(ready), 64'b0010);
    tick();
    chk("conf_stall_n", 64'(stall), 64'd1);
    chk("conf_w1d_n", 64'(w1d), 64'hA1);
    chk("conf_w2en_n", 64'(w2en), 64'd0);
    v[1] = 1'b0;
    #1;
    chk("conf_ready_n1", 64'(ready), 64'b1000);
    tick();
    chk("conf_w1d_n1", 64'(w1d), 64'hB3);
    chk("conf_stall_n1", 64'(stall), 64'd1);
    clear_reqs();
    tick();
    chk("conf_ram5", 64'(shadow[5]), 64'hB3);
    do_reset();

    // fairness with four held distinct requests
    set_req(0, 5'd1, 32'h100);
    set_req(1, 5'd2, 32'h101);
    set_req(2, 5'd4, 32'h102);
    set_req(3, 5'd6, 32'h103);
    #1;
    chk("fair_r0", 64'(ready), 64'b0011);
    tick();
    chk("fair_r1", 64'(ready), 64'b1100);
    chk("fair_w2d", 64'(w2d), 64'h101);
    tick();
    chk("fair_r2", 64'(ready), 64'b0011);
    chk("fair_w1a", 64'(w1a), 64'd4);
    clear_reqs();
    tick();

    // address zero accepted but not issued
    set_req(0, 5'd0, 32'hDEAD);
    #1;
    chk("zero_ready", 64'(ready), 64'b0001);
    tick();
    chk("zero_w1en", 64'(w1en), 64'd0);
    clear_reqs();
    do_reset();

    // stall counter saturation, then asynchronous reset mid-run
    set_req(0, 5'd8, 32'hC0);
    set_req(1, 5'd8, 32'hC1);
    set_req(2, 5'd8, 32'hC2);
    repeat (70000) tick();
    chk("sat_stall", 64'(stall), 64'hFFFF);
    chk("sat_w1en", 64'(w1en), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_w1en", 64'(w1en), 64'd0);
    chk("arst_w1a", 64'(w1a), 64'd0);
    chk("arst_w1d", 64'(w1d), 64'd0);
    chk("arst_w2en", 64'(w2en), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_ready", 64'(ready), 64'd0);
    clear_reqs();
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
